dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the MIPS64 pipeline's memory-access stage. It accepts single read and/or write requests (re/we, length code, address, write data), models a fixed access latency with a wait-state counter, and performs byte/half/word accesses on an internal little-endian word array. It answers each request with a one-cycle ack and raw, zero-extended read data; sign extension is the requester's job. It sits between the MA stage's memory port and the (future) cache/bus.

## Interface

Parameters:
- `MADDR_L`, default 32: byte-address width.
- `DATA_L`, default 32: data width. Fixed at 32.
- `MEM_WORDS`, default 1024: array depth in words. Must be a power of 2.
- `LATENCY`, default 2: wait cycles inserted between accept and ack. Range 0..15.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `re` in 1: read request.
- `we` in 1: write request.
- `rlen` in 2: read length. 00 = byte, 01 = half, 11 = word, 10 = illegal.
- `wlen` in 2: write length, same encoding as `rlen`.
- `raddr` in MADDR_L: read byte address.
- `waddr` in MADDR_L: write byte address.
- `wdata` in DATA_L: write data, right-aligned. Byte uses [7:0]; half uses [15:0].
- `rdata` out DATA_L: read data, zero-extended. Valid while `ack` is high.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: high from accept until ack, inclusive.
- `err` out 1: one-cycle pulse, coincident with `ack`, for a faulted request.

## Operation

- FSM states: IDLE, WAIT, RESP.
- **IDLE.** At a rising edge with `busy` low and `re | we` high, the block:
  - latches `re`, `we`, `rlen`, `wlen`, `raddr`, `waddr` and `wdata`;
  - loads the wait counter with LATENCY;
  - goes to WAIT if LATENCY > 0, otherwise to RESP.
- **WAIT.** The counter decrements each cycle. When it reaches 1, the FSM goes to RESP.
- **RESP.** For exactly one cycle:
  - `ack` = 1;
  - the write, if any, is committed at the exit edge;
  - `rdata` is driven;
  - the FSM returns to IDLE.
- Requests raised while `busy` = 1 are ignored, not queued. The requester holds or re-raises `re`/`we` after `busy` falls.
- Word index is addr[log2(MEM_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap modulo MEM_WORDS×4 bytes.
- Lane select is little-endian:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0}+1 : {addr[1],0};
  - word: all four lanes.
- Reads return the selected bytes in rdata[7:0] or rdata[15:0], with upper bits 0.
- Writes update only the selected byte lanes. Other lanes keep their values.
- **Simultaneous re and we.** Both are performed as one transaction. The read observes the data after the write (read-after-write), including partial lane overlap.
- **Length code 10 on an enabled side.** `err` = 1 with `ack`, no write is performed, and `rdata` = 0.
- **Reset.** Outputs `rdata` = 0, `ack` = 0, `busy` = 0, `err` = 0. FSM goes to IDLE and the counter to 0. Array contents are not cleared.
- **Reset mid-transaction.** The pending write is dropped and no ack is issued.

## Timing

- Request sampled at edge T.
- `busy` is high from T.
- `ack`, `rdata` and `err` are valid in the cycle after edge T+LATENCY+1. With LATENCY = 0, ack follows at T+1.
- `busy` falls at edge T+LATENCY+2, together with `ack`.
- Total latency is LATENCY+1 cycles from accept to ack.
- The earliest next accept is edge T+LATENCY+2.
- Throughput is one request per LATENCY+2 cycles.
- Array write commits at the edge ending RESP, so a following read sees it.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- `DMEM_ALIGN_CHECK_EN`
  - Defined:
    - a half access with addr[0] ≠ 0 is misaligned;
    - a word access with addr[1:0] ≠ 0 is misaligned;
    - a misaligned access raises `err` with its `ack`;
    - the faulted side is suppressed: no write, and `rdata` = 0;
    - a non-faulted other side of a simultaneous request still completes.
  - Undefined: low address bits are forced to alignment (half clears bit 0, word clears bits 1:0). `err` is raised only for length code 10.

## Test plan

- **Reset value.** Assert rst mid-WAIT of a word write of 0xDEADBEEF to 0x10 → no ack, busy = 0, and a later word read of 0x10 returns the prior contents.
- **Word write then read, LATENCY = 2.** Write 0x12345678 to 0x40 → ack exactly 3 cycles after accept. Word read of 0x40 → rdata = 0x12345678.
- **Partial writes.**
  - Write byte 0xAA to 0x41 → a word read of 0x40 returns 0x1234AA78.
  - Write half 0xBEEF to 0x42 → a word read of 0x40 returns 0xBEEFAA78.
  - Byte read of 0x43 → 0x000000BE.
- **Simultaneous re and we.** Write word 0xCAFEF00D to 0x80 while reading half at 0x82 in the same cycle → one ack with rdata = 0x0000CAFE.
- **Busy and ignore.** Pulse re at accept+1 with a different address → no second ack. busy timing is T..T+LATENCY+2. LATENCY = 0 build: ack at T+1.
- **Error and alignment.**
  - rlen = 10 → err = ack = 1, rdata = 0.
  - With DMEM_ALIGN_CHECK_EN, word write to 0x41 → err and memory unchanged.
  - Without it, the same write lands at 0x40.
  - Wrap check: address MEM_WORDS×4 aliases to 0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the MA stage and the data-memory responder
//
// Signals:
//   re, we         read / write request strobes (requester -> responder)
//   rlen, wlen     length codes: 00 byte, 01 half, 11 word, 10 illegal
//   raddr, waddr   byte addresses, MADDR_L bits
//   wdata          right-aligned write data, DATA_L bits
//   rdata          zero-extended read data, valid while ack is high
//   ack            one-cycle completion pulse
//   busy           high from accept until ack, inclusive
//   err            one-cycle fault pulse, coincident with ack
//
// Modports: master = requester side, slave = responder side.

interface dmem_responder_if #(
    parameter int MADDR_L = 32,
    parameter int DATA_L  = 32
);
    logic               re;
    logic               we;
    logic [1:0]         rlen;
    logic [1:0]         wlen;
    logic [MADDR_L-1:0] raddr;
    logic [MADDR_L-1:0] waddr;
    logic [DATA_L-1:0]  wdata;
    logic [DATA_L-1:0]  rdata;
    logic               ack;
    logic               busy;
    logic               err;

    modport master (
        output re, we, rlen, wlen, raddr, waddr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  re, we, rlen, wlen, raddr, waddr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency byte/half/word data-memory responder for the MA stage
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous, active-high reset
//   bus   dmem_responder_if.slave (re/we/rlen/wlen/raddr/waddr/wdata in,
//         rdata/ack/busy/err out, all outputs registered)
//
// Parameters:
//   MADDR_L    byte-address width
//   DATA_L     data width, fixed at 32
//   MEM_WORDS  array depth in words, power of 2
//   LATENCY    wait cycles between accept and response, 0..15
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses fault (err, side suppressed)
//   undefined : low address bits are forced to alignment, err only for code 10
//
// Timing for a request accepted at edge T:
//   busy rises at T, ack/rdata/err are high for the cycle after T+LATENCY+1,
//   busy falls at T+LATENCY+2, which is also the earliest next accept.

module dmem_responder #(
    parameter int MADDR_L   = 32,
    parameter int DATA_L    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_responder_if.slave bus
);

    localparam int         IDX_L = $clog2(MEM_WORDS);
    // Address bits actually needed: word index plus the two lane bits.
    localparam int         LOW_L = IDX_L + 2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_BAD  = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [3:0]         cnt;

    // Request captured at accept; only the index and lane bits of the
    // addresses matter because the array wraps modulo MEM_WORDS*4 bytes.
    logic               lat_re;
    logic               lat_we;
    logic [1:0]         lat_rlen;
    logic [1:0]         lat_wlen;
    logic [LOW_L-1:0]   lat_raddr;
    logic [LOW_L-1:0]   lat_waddr;
    logic [DATA_L-1:0]  lat_wdata;

    logic [DATA_L-1:0]  mem [MEM_WORDS];

    // Upper address bits are deliberately ignored (aliasing).
    logic               unused_addr_hi;
    assign unused_addr_hi = ^{bus.raddr[MADDR_L-1:LOW_L], bus.waddr[MADDR_L-1:LOW_L]};

    // ------------------------------------------------------------------
    // Response datapath, evaluated from the latched request.
    // ------------------------------------------------------------------
    logic [1:0]         w_lo;
    logic [1:0]         r_lo;
    logic [1:0]         w_sel;
    logic [1:0]         r_sel;
    logic               w_fault;
    logic               r_fault;
    logic               w_ok;
    logic               r_ok;
    logic [IDX_L-1:0]   w_idx;
    logic [IDX_L-1:0]   r_idx;
    logic [3:0]         w_be;
    logic [DATA_L-1:0]  w_mask;
    logic [DATA_L-1:0]  w_shift;
    logic [DATA_L-1:0]  w_old;
    logic [DATA_L-1:0]  w_merged;
    logic [DATA_L-1:0]  r_word;
    logic [DATA_L-1:0]  r_shift;
    logic [DATA_L-1:0]  r_data;
    logic [DATA_L-1:0]  rd_val;
    logic               err_next;

    always_comb begin
        w_lo = lat_waddr[1:0];
        r_lo = lat_raddr[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned accesses fault instead of being silently realigned.
        w_fault = (lat_wlen == LEN_BAD)
               || (lat_wlen == LEN_HALF && w_lo[0])
               || (lat_wlen == LEN_WORD && w_lo != 2'b00);
        r_fault = (lat_rlen == LEN_BAD)
               || (lat_rlen == LEN_HALF && r_lo[0])
               || (lat_rlen == LEN_WORD && r_lo != 2'b00);
        w_sel   = w_lo;
        r_sel   = r_lo;
`else
        // Low bits are forced to the natural alignment of the length.
        w_fault = (lat_wlen == LEN_BAD);
        r_fault = (lat_rlen == LEN_BAD);
        w_sel   = (lat_wlen == LEN_HALF) ? {w_lo[1], 1'b0} :
                  (lat_wlen == LEN_WORD) ? 2'b00 : w_lo;
        r_sel   = (lat_rlen == LEN_HALF) ? {r_lo[1], 1'b0} :
                  (lat_rlen == LEN_WORD) ? 2'b00 : r_lo;
`endif

        w_ok     = lat_we & ~w_fault;
        r_ok     = lat_re & ~r_fault;
        err_next = (lat_we & w_fault) | (lat_re & r_fault);

        w_idx = lat_waddr[LOW_L-1:2];
        r_idx = lat_raddr[LOW_L-1:2];

        // Little-endian byte enables for the write.
        case (lat_wlen)
            LEN_BYTE: w_be = 4'b0001 << w_sel;
            LEN_HALF: w_be = 4'b0011 << w_sel;
            default:  w_be = 4'b1111;
        endcase

        w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
        w_shift  = lat_wdata << {w_sel, 3'b000};
        w_old    = mem[w_idx];
        w_merged = (w_old & ~w_mask) | (w_shift & w_mask);

        // Read-after-write within one transaction: when both sides hit the
        // same word, the read sees the merged word, so partial lane overlap
        // is handled for free.
        r_word  = (w_ok && (w_idx == r_idx)) ? w_merged : mem[r_idx];
        r_shift = r_word >> {r_sel, 3'b000};

        case (lat_rlen)
            LEN_BYTE: r_data = {{(DATA_L-8){1'b0}}, r_shift[7:0]};
            LEN_HALF: r_data = {{(DATA_L-16){1'b0}}, r_shift[15:0]};
            default:  r_data = r_shift;
        endcase

        rd_val = r_ok ? r_data : '0;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bus.ack   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
            lat_re    <= 1'b0;
            lat_we    <= 1'b0;
            lat_rlen  <= 2'b00;
            lat_wlen  <= 2'b00;
            lat_raddr <= '0;
            lat_waddr <= '0;
            lat_wdata <= '0;
        end else begin
            // ack, err and rdata are single-cycle unless RESP sets them.
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;

            case (state)
                IDLE: begin
                    // IDLE also covers the ack cycle, where busy is still
                    // high; accepting here gives one request per LATENCY+2.
                    if (bus.re || bus.we) begin
                        lat_re    <= bus.re;
                        lat_we    <= bus.we;
                        lat_rlen  <= bus.rlen;
                        lat_wlen  <= bus.wlen;
                        lat_raddr <= bus.raddr[LOW_L-1:0];
                        lat_waddr <= bus.waddr[LOW_L-1:0];
                        lat_wdata <= bus.wdata;
                        cnt       <= LAT;
                        bus.busy  <= 1'b1;
                        state     <= (LAT != 4'd0) ? WAIT : RESP;
                    end else begin
                        bus.busy  <= 1'b0;
                    end
                end

                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end

                RESP: begin
                    // busy stays high through the ack cycle and drops on
                    // the following edge from IDLE.
                    bus.ack   <= 1'b1;
                    bus.err   <= err_next;
                    bus.rdata <= rd_val;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Array write, committed at the edge that ends RESP. The array is not
    // reset; a reset forces the FSM out of RESP, dropping a pending write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && w_ok) begin
            mem[w_idx] <= w_merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder

module tb_dmem_responder;

    logic clk;
    logic rst;

    int total;
    int bad;

    dmem_responder_if #(.MADDR_L(32), .DATA_L(32)) bus ();
    dmem_responder_if #(.MADDR_L(32), .DATA_L(32)) bus0 ();

    dmem_responder #(
        .MADDR_L(32), .DATA_L(32), .MEM_WORDS(1024), .LATENCY(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_responder #(
        .MADDR_L(32), .DATA_L(32), .MEM_WORDS(1024), .LATENCY(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance. lat counts edges from
    // accept to the first sample with ack high; -1 if ack never came.
    task automatic xact(input logic r, input logic w,
                        input logic [1:0] rl, input logic [1:0] wl,
                        input logic [31:0] ra, input logic [31:0] wa,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        bus.re = r; bus.we = w; bus.rlen = rl; bus.wlen = wl;
        bus.raddr = ra; bus.waddr = wa; bus.wdata = wd;
        @(posedge clk); #1;
        bus.re = 1'b0; bus.we = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.ack && lat < 40);
        if (!bus.ack) lat = -1;
        rd = bus.rdata;
        e  = bus.err;
        @(posedge clk); #1;
    endtask

    task automatic wr(input string tag, input logic [1:0] len, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err);
        logic [31:0] rdv; logic e; int lat;
        xact(1'b0, 1'b1, 2'b11, len, 32'h0, a, d, rdv, e, lat);
        chk({tag, "_lat"}, lat, 32'd3);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd(input string tag, input logic [1:0] len, input logic [31:0] a,
                      input logic [31:0] exp, input logic exp_err);
        logic [31:0] rdv; logic e; int lat;
        xact(1'b1, 1'b0, len, 2'b11, a, 32'h0, 32'h0, rdv, e, lat);
        chk({tag, "_lat"}, lat, 32'd3);
        chk({tag, "_data"}, rdv, exp);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] rdv;
        logic        e;
        int          lat;
        int          acks;
        int          ack_at;
        logic [31:0] ack_data;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.re = 1'b0; bus.we = 1'b0; bus.rlen = 2'b00; bus.wlen = 2'b00;
        bus.raddr = '0; bus.waddr = '0; bus.wdata = '0;
        bus0.re = 1'b0; bus0.we = 1'b0; bus0.rlen = 2'b00; bus0.wlen = 2'b00;
        bus0.raddr = '0; bus0.waddr = '0; bus0.wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   {31'd0, bus.ack},  32'd0);
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_err",   {31'd0, bus.err},  32'd0);
        chk("rst_rdata", bus.rdata,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a write drops it.
        wr("pre10", 2'b11, 32'h10, 32'h11112222, 1'b0);
        @(negedge clk);
        bus.we = 1'b1; bus.wlen = 2'b11; bus.waddr = 32'h10; bus.wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.we = 1'b0;
        chk("mid_busy_before", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_ack",  {31'd0, bus.ack},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.ack) acks++;
        end
        chk("mid_rst_noack", acks, 32'd0);
        rd("post10", 2'b11, 32'h10, 32'h11112222, 1'b0);

        // Word write/read and partial lane updates.
        wr("w40", 2'b11, 32'h40, 32'h12345678, 1'b0);
        rd("r40", 2'b11, 32'h40, 32'h12345678, 1'b0);
        wr("wb41", 2'b00, 32'h41, 32'h000000AA, 1'b0);
        rd("r40b", 2'b11, 32'h40, 32'h1234AA78, 1'b0);
        wr("wh42", 2'b01, 32'h42, 32'h0000BEEF, 1'b0);
        rd("r40h", 2'b11, 32'h40, 32'hBEEFAA78, 1'b0);
        rd("rb43", 2'b00, 32'h43, 32'h000000BE, 1'b0);
        rd("rh42", 2'b01, 32'h42, 32'h0000BEEF, 1'b0);
        rd("rb40", 2'b00, 32'h40, 32'h00000078, 1'b0);

        // Simultaneous read and write, read sees the write.
        xact(1'b1, 1'b1, 2'b01, 2'b11, 32'h82, 32'h80, 32'hCAFEF00D, rdv, e, lat);
        chk("rw_lat",  lat, 32'd3);
        chk("rw_data", rdv, 32'h0000CAFE);
        chk("rw_err",  {31'd0, e}, 32'd0);
        xact(1'b1, 1'b1, 2'b11, 2'b00, 32'h80, 32'h81, 32'h00000055, rdv, e, lat);
        chk("rw2_data", rdv, 32'hCAFE550D);

        // Requests while busy are ignored; busy spans T..T+LATENCY+2.
        @(negedge clk);
        bus.re = 1'b1; bus.rlen = 2'b11; bus.raddr = 32'h40;
        @(posedge clk); #1;
        chk("bz_busy0", {31'd0, bus.busy}, 32'd1);
        bus.raddr = 32'h80;
        acks = 0; ack_at = -1; ack_data = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            bus.re = 1'b0;
            if (bus.ack) begin
                acks++;
                ack_at = k;
                ack_data = bus.rdata;
            end
            if (k <= 5) chk($sformatf("bz_busy%0d", k), {31'd0, bus.busy}, (k <= 3) ? 32'd1 : 32'd0);
        end
        chk("bz_acks",  acks, 32'd1);
        chk("bz_at",    ack_at, 32'd3);
        chk("bz_data",  ack_data, 32'hBEEFAA78);

        // Illegal length codes.
        rd("rbad", 2'b10, 32'h40, 32'h0, 1'b1);
        wr("wbad", 2'b10, 32'h40, 32'h0, 1'b1);
        rd("r40_after_bad", 2'b11, 32'h40, 32'hBEEFAA78, 1'b0);

        // Alignment handling.
`ifdef DMEM_ALIGN_CHECK_EN
        wr("wmis", 2'b11, 32'h41, 32'h99887766, 1'b1);
        rd("r40_mis", 2'b11, 32'h40, 32'hBEEFAA78, 1'b0);
        rd("rhmis", 2'b01, 32'h43, 32'h0, 1'b1);
`else
        wr("wmis", 2'b11, 32'h41, 32'h99887766, 1'b0);
        rd("r40_mis", 2'b11, 32'h40, 32'h99887766, 1'b0);
        rd("rhmis", 2'b01, 32'h43, 32'h00009988, 1'b0);
`endif

        // Wrap: MEM_WORDS*4 aliases to byte 0.
        wr("wwrap", 2'b11, 32'h1000, 32'hA5A50001, 1'b0);
        rd("rwrap", 2'b11, 32'h0, 32'hA5A50001, 1'b0);

        // LATENCY = 0 instance: ack one edge after accept.
        @(negedge clk);
        bus0.we = 1'b1; bus0.wlen = 2'b11; bus0.waddr = 32'h4; bus0.wdata = 32'h01020304;
        @(posedge clk); #1;
        bus0.we = 1'b0;
        chk("l0_busy0", {31'd0, bus0.busy}, 32'd1);
        chk("l0_ack0",  {31'd0, bus0.ack},  32'd0);
        @(posedge clk); #1;
        chk("l0_ack1",  {31'd0, bus0.ack},  32'd1);
        chk("l0_busy1", {31'd0, bus0.busy}, 32'd1);
        @(posedge clk); #1;
        chk("l0_ack2",  {31'd0, bus0.ack},  32'd0);
        chk("l0_busy2", {31'd0, bus0.busy}, 32'd0);
        @(negedge clk);
        bus0.re = 1'b1; bus0.rlen = 2'b11; bus0.raddr = 32'h4;
        @(posedge clk); #1;
        bus0.re = 1'b0;
        @(posedge clk); #1;
        chk("l0_rack",  {31'd0, bus0.ack}, 32'd1);
        chk("l0_rdata", bus0.rdata, 32'h01020304);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
